seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the source end of the 1010 detection path.

---
 rtl/seq_pattern_tx.sv | 122 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first, repeated with optional idle gaps.
// Latency 1 from accepted start to first bit; start is ignored while busy; abort cancels a running burst with no done.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  output logic             data_out,
  output logic             data_valid,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [GAP_W-1:0] gap;
  } cfg_t;

  state_t           state, n_state;
  cfg_t             cfg, n_cfg;
  logic [CNT_W-1:0] rep_cnt, n_rep_cnt;
  logic [GAP_W-1:0] gap_cnt, n_gap_cnt;
  logic [IDX_W-1:0] idx, n_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cfg     <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      idx     <= '0;
    end else begin
      state   <= n_state;
      cfg     <= n_cfg;
      rep_cnt <= n_rep_cnt;
      gap_cnt <= n_gap_cnt;
      idx     <= n_idx;
    end
  end

  // rep_cnt holds the repetitions still to send, including the one in flight.
  always_comb begin
    n_state   = state;
    n_cfg     = cfg;
    n_rep_cnt = rep_cnt;
    n_gap_cnt = gap_cnt;
    n_idx     = idx;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          n_cfg.pat = pattern;
          n_cfg.gap = gap;
          n_rep_cnt = repeats;
          n_idx     = IDX_MAX;
          n_state   = (repeats != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (abort) begin
          n_state = IDLE;
        end else if (idx == '0) begin
          if (rep_cnt == CNT_W'(1)) begin
            n_state = DONE;
          end else begin
            n_rep_cnt = rep_cnt - CNT_W'(1);
            if (cfg.gap != '0) begin
              n_state   = GAP;
              n_gap_cnt = cfg.gap;
            end else begin
              n_idx = IDX_MAX;
            end
          end
        end else begin
          n_idx = idx - IDX_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          n_state = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          n_state = SEND;
          n_idx   = IDX_MAX;
        end else begin
          n_gap_cnt = gap_cnt - GAP_W'(1);
        end
      end
      DONE: n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      data_out   <= (n_state == SEND) && n_cfg.pat[n_idx];
      data_valid <= (n_state == SEND);
      last       <= (n_state == SEND) && (n_idx == '0) && (n_rep_cnt == CNT_W'(1));
      busy       <= (n_state != IDLE);
      done       <= (n_state == DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized and directed bench for seq_pattern_tx against a per-cycle expected-output model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] repeats = '0;
  logic [3:0] gap = '0;
  logic       data_out, data_valid, last, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  int burst_id = 0;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .repeats(repeats), .gap(gap),
    .data_out(data_out), .data_valid(data_valid), .last(last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outv();
    return {data_out, data_valid, last, busy, done};
  endfunction

  // Expected per-cycle outputs {data_out,data_valid,last,busy,done} built from the burst description.
  task automatic run_burst(input logic [3:0] pat, input int reps, input int gp,
                           input int abort_cyc, input int spam_cyc, input int det_exp);
    logic [4:0] q[$];
    logic [3:0] sh;
    int n_full, det, busy_n;
    bit aborted;
    q = {};
    for (int r = 0; r < reps; r++) begin
      for (int b = 3; b >= 0; b--)
        q.push_back({pat[b], 1'b1, (r == reps - 1) && (b == 0), 1'b1, 1'b0});
      if (r < reps - 1)
        for (int g = 0; g < gp; g++) q.push_back(5'b00010);
    end
    q.push_back(5'b00011);
    n_full = q.size();
    aborted = (abort_cyc > 0) && (abort_cyc < n_full);
    if (aborted)
      while (q.size() > abort_cyc) void'(q.pop_back());
    q.push_back(5'b00000);
    if (spam_cyc >= q.size()) spam_cyc = 0;

    burst_id++;
    pattern = pat;
    repeats = reps[7:0];
    gap     = gp[3:0];
    start   = 1'b1;
    abort   = 1'b0;
    sh = '0; det = 0; busy_n = 0;
    for (int k = 1; k <= q.size(); k++) begin
      @(negedge clk);
      chk($sformatf("burst%0d_cyc%0d", burst_id, k), {27'b0, outv()}, {27'b0, q[k-1]});
      if (busy) busy_n++;
      sh = {sh[2:0], data_out};
      if (sh == 4'b1010) det++;
      start   = (k == spam_cyc);
      abort   = (k == abort_cyc);
      pattern = 4'($urandom);
      repeats = 8'($urandom);
      gap     = 4'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    if (!aborted)
      chk($sformatf("burst%0d_busy_cycles", burst_id), busy_n,
          (reps > 0) ? reps * 4 + (reps - 1) * gp + 1 : 1);
    if (det_exp >= 0)
      chk($sformatf("burst%0d_det1010", burst_id), det, det_exp);
  endtask

  initial begin
    #12;
    chk("reset_outputs", {27'b0, outv()}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {27'b0, outv()}, 32'h0);

    run_burst(4'b1010, 1, 0, 0, 0, -1);
    run_burst(4'b1010, 3, 0, 0, 0, 5);
    run_burst(4'b1010, 3, 1, 0, 0, 3);
    run_burst(4'b1010, 0, 0, 0, 1, 0);
    run_burst(4'b1100, 2, 2, 0, 3, -1);
    run_burst(4'b1010, 2, 0, 3, 0, -1);
    run_burst(4'b0110, 2, 1, 0, 0, -1);
    run_burst(4'b1001, 1, 0, 5, 0, -1);
    run_burst(4'b1011, 2, 3, 6, 0, -1);

    // abort and start together in IDLE: start must be dropped
    start = 1'b1; abort = 1'b1; pattern = 4'b1111; repeats = 8'd2;
    @(negedge clk);
    chk("abort_start_idle_c1", {27'b0, outv()}, 32'h0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_idle_c2", {27'b0, outv()}, 32'h0);

    run_burst(4'b1010, 255, 1, 0, 0, -1);

    // async reset in the middle of a gap
    pattern = 4'b1010; repeats = 8'd3; gap = 4'd3; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_in_gap", {27'b0, outv()}, 32'h02);
    #2 rst = 1'b0;
    #1 chk("async_reset_mid_gap", {27'b0, outv()}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("idle_after_release%0d", k), {27'b0, outv()}, 32'h0);
    end

    for (int i = 0; i < 25; i++) begin
      automatic logic [3:0] p = 4'($urandom);
      automatic int r  = $urandom_range(0, 5);
      automatic int g  = $urandom_range(0, 3);
      automatic int ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
      automatic int sp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      run_burst(p, r, g, ab, sp, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
